deadlock_block_timeout_reporter: RTL and testbench
==================================================

Name: deadlock_block_timeout_reporter

Overview:
- Sits directly downstream of the kernel deadlock monitor. Consumes its per-kernel `kernel_block` flag and the raw per-port AXIS/instance block vectors.
- Distinguishes transient back-pressure from a true deadlock: a deadlock is a block that persists for TIMEOUT consecutive cycles.
- On a true deadlock it latches a sticky report for the simulation/debug side: which ports were blocked, the first blocked port, and the cycle count.

Parameters:
- NUM_AXIS, 1, number of AXIS block lines monitored (≥1).
- NUM_INST, 1, number of sub-instance block lines monitored (≥1).
- TIMEOUT, 1024, consecutive blocked cycles that declare a deadlock (≥2).
- CNT_W, 32, width of the cycle and event counters.
- IDX_W, $clog2(NUM_AXIS+NUM_INST) (minimum 1), width of the port index.

Ports:
- clock, in, 1, kernel monitor clock.
- reset_n, in, 1, asynchronous active-low reset.
- kernel_block, in, 1, block flag from the kernel monitor.
- axis_block_sigs, in, NUM_AXIS, per-port AXIS blocked (1 = blocked).
- inst_block_sigs, in, NUM_INST, per-instance blocked.
- clear, in, 1, synchronous single-cycle clear of the sticky report.
- deadlock, out, 1, sticky deadlock-declared flag.
- deadlock_pulse, out, 1, one-cycle strobe on declaration.
- blocked_snapshot, out, NUM_AXIS+NUM_INST, captured {inst_block_sigs, axis_block_sigs} at declaration.
- first_blocked_idx, out, IDX_W, lowest set index of the snapshot.
- snapshot_valid, out, 1, 1 when the snapshot has at least one bit set.
- block_cycles, out, CNT_W, current consecutive-block run length, saturating.
- transient_count, out, CNT_W, number of block runs that ended before TIMEOUT, saturating.

Behaviour:
- All state is on the rising edge of clock. reset_n is asynchronous assert, synchronous release. Reset mid-operation aborts any run and returns to IDLE immediately.
- Reset values: every output is 0; the FSM is in IDLE.
- FSM states are IDLE, COUNTING and DEADLOCK.
- IDLE:
  - kernel_block=1 → COUNTING with block_cycles=1.
  - Otherwise stay in IDLE with block_cycles=0.
- COUNTING:
  - kernel_block=0 → IDLE, block_cycles←0, transient_count+1 (saturates at all-ones).
  - kernel_block=1 and block_cycles==TIMEOUT-1 → DEADLOCK. On that edge: block_cycles←TIMEOUT, deadlock←1, deadlock_pulse←1 for exactly one cycle, and blocked_snapshot captures the inputs sampled in that same cycle.
  - Otherwise block_cycles+1.
- DEADLOCK:
  - deadlock, snapshot and first_blocked_idx are held regardless of kernel_block.
  - block_cycles keeps incrementing while kernel_block=1 and saturates at all-ones. It holds its value when kernel_block=0.
  - No new pulse is generated while in DEADLOCK.
- first_blocked_idx and snapshot_valid are registered and derived from the snapshot. For an all-zero snapshot (kernel block with no port bits set): snapshot_valid=0 and first_blocked_idx=0.
- clear:
  - Any state → IDLE next cycle.
  - Zeroes deadlock, snapshot, first_blocked_idx, snapshot_valid and block_cycles.
  - transient_count is preserved.
- clear has priority over all transitions. If clear coincides with the declaring edge, no pulse occurs and the result is IDLE.
- If clear is asserted while kernel_block=1, the next cycle is IDLE. Counting restarts at 1 on the following cycle if the block persists.
- The counters never wrap; saturation is mandatory.
- Latency: deadlock asserts TIMEOUT cycles after the first sampled kernel_block=1.

Decomposition:
- Package deadlock_report_pkg holds:
  - the state enum (IDLE, COUNTING, DEADLOCK);
  - the CNT_W default;
  - a saturating-increment function.
- One natural sub-module: deadlock_prio_encoder. It is a parameterized lowest-set-bit encoder of width N, with outputs idx and any, used for first_blocked_idx and snapshot_valid.

Test Plan:
- Use TIMEOUT=8, NUM_AXIS=2 and NUM_INST=1 throughout.
- Transient run: kernel_block high 5 cycles then low → no deadlock, block_cycles returns to 0, transient_count=1.
- Declaration: kernel_block held high, axis_block_sigs=2'b10, inst=0 → deadlock_pulse high exactly on the 8th cycle with block_cycles=8, blocked_snapshot=3'b010, first_blocked_idx=1, snapshot_valid=1.
- Sticky behaviour: after declaration, drop kernel_block and change axis_block_sigs=2'b01 → deadlock stays 1, snapshot stays 3'b010, no second pulse.
- Clear: pulse clear in DEADLOCK → next cycle all report outputs are 0 and transient_count is unchanged. Then clear coincident with the 8th blocked cycle → no pulse, state IDLE.
- Async reset: assert reset_n=0 at block_cycles=5 between clock edges → outputs zero immediately. After release, a fresh 8-cycle block is required to declare.
- Empty snapshot and saturation: run kernel_block=1 with all port bits 0 → snapshot_valid=0, first_blocked_idx=0. With CNT_W=4, hold the block → block_cycles saturates at 15.

Source files
------------

// File: rtl/deadlock_report_pkg.sv
// Shared types and helpers for the deadlock timeout reporter.
package deadlock_report_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    DEADLOCK = 2'd2
  } dl_state_e;

  localparam int CNT_W_DEF = 32;
  localparam int SAT_W     = 64;

  // Increment v, clamping at the all-ones value of a w-bit counter.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input int unsigned     w);
    logic [SAT_W-1:0] lim;
    lim = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
    return (v >= lim) ? lim : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/deadlock_block_timeout_reporter_prio_encoder.sv
// Lowest-set-bit encoder: idx of the first set bit, any when at least one is set.
module deadlock_prio_encoder #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = |vec;
    // Scan downward so the lowest set bit wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/deadlock_block_timeout_reporter.sv
// Turns the kernel block flag into a sticky deadlock report once the block
// persists for TIMEOUT cycles; shorter runs are counted as transients.
module deadlock_block_timeout_reporter
  import deadlock_report_pkg::*;
#(
  parameter int NUM_AXIS = 1,
  parameter int NUM_INST = 1,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int IDX_W    = ((NUM_AXIS + NUM_INST) > 1) ? $clog2(NUM_AXIS + NUM_INST) : 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         kernel_block,
  input  logic [NUM_AXIS-1:0]          axis_block_sigs,
  input  logic [NUM_INST-1:0]          inst_block_sigs,
  input  logic                         clear,
  output logic                         deadlock,
  output logic                         deadlock_pulse,
  output logic [NUM_AXIS+NUM_INST-1:0] blocked_snapshot,
  output logic [IDX_W-1:0]             first_blocked_idx,
  output logic                         snapshot_valid,
  output logic [CNT_W-1:0]             block_cycles,
  output logic [CNT_W-1:0]             transient_count
);

  localparam int NP = NUM_AXIS + NUM_INST;

  dl_state_e        state_q, state_d;
  logic [NP-1:0]    port_vec;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;

  logic             deadlock_d, pulse_d, valid_d;
  logic [NP-1:0]    snap_d;
  logic [IDX_W-1:0] idx_d;
  logic [CNT_W-1:0] bc_d, tc_d, bc_inc, tc_inc;
  logic             at_limit;

  assign port_vec = {inst_block_sigs, axis_block_sigs};
  assign bc_inc   = CNT_W'(sat_inc(SAT_W'(block_cycles), CNT_W));
  assign tc_inc   = CNT_W'(sat_inc(SAT_W'(transient_count), CNT_W));
  assign at_limit = (block_cycles == CNT_W'(TIMEOUT - 1));

  // Encode the live port vector so idx/valid register on the same edge as the snapshot.
  deadlock_prio_encoder #(
    .N    (NP),
    .IDX_W(IDX_W)
  ) u_prio (
    .vec(port_vec),
    .idx(enc_idx),
    .any(enc_any)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (kernel_block) state_d = COUNTING;
        COUNTING: begin
          if (!kernel_block) state_d = IDLE;
          else if (at_limit) state_d = DEADLOCK;
        end
        DEADLOCK: state_d = DEADLOCK;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    deadlock_d = deadlock;
    pulse_d    = 1'b0;
    snap_d     = blocked_snapshot;
    idx_d      = first_blocked_idx;
    valid_d    = snapshot_valid;
    bc_d       = block_cycles;
    tc_d       = transient_count;
    if (clear) begin
      // Report is wiped; the transient history survives.
      deadlock_d = 1'b0;
      snap_d     = '0;
      idx_d      = '0;
      valid_d    = 1'b0;
      bc_d       = '0;
    end else begin
      case (state_q)
        IDLE: bc_d = kernel_block ? CNT_W'(1) : '0;
        COUNTING: begin
          if (!kernel_block) begin
            bc_d = '0;
            tc_d = tc_inc;
          end else if (at_limit) begin
            bc_d       = CNT_W'(TIMEOUT);
            deadlock_d = 1'b1;
            pulse_d    = 1'b1;
            snap_d     = port_vec;
            idx_d      = enc_idx;
            valid_d    = enc_any;
          end else begin
            bc_d = bc_inc;
          end
        end
        DEADLOCK: if (kernel_block) bc_d = bc_inc;
        default:  bc_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      deadlock          <= 1'b0;
      deadlock_pulse    <= 1'b0;
      blocked_snapshot  <= '0;
      first_blocked_idx <= '0;
      snapshot_valid    <= 1'b0;
      block_cycles      <= '0;
      transient_count   <= '0;
    end else begin
      deadlock          <= deadlock_d;
      deadlock_pulse    <= pulse_d;
      blocked_snapshot  <= snap_d;
      first_blocked_idx <= idx_d;
      snapshot_valid    <= valid_d;
      block_cycles      <= bc_d;
      transient_count   <= tc_d;
    end
  end

endmodule

// File: tb/tb_deadlock_block_timeout_reporter.sv
// Directed scoreboard bench: TIMEOUT=8, two AXIS lines, one instance line, 4-bit counters.
module tb_deadlock_block_timeout_reporter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       kernel_block = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] axis_block_sigs = '0;
  logic [0:0] inst_block_sigs = '0;
  logic       deadlock, deadlock_pulse, snapshot_valid;
  logic [2:0] blocked_snapshot;
  logic [1:0] first_blocked_idx;
  logic [3:0] block_cycles, transient_count;

  typedef struct {
    string      tag;
    logic       dl;
    logic       pl;
    logic [2:0] snap;
    logic [1:0] idx;
    logic       val;
    logic [3:0] bc;
    logic [3:0] tc;
  } exp_t;

  exp_t sb[$];
  int passed = 0, total = 0, failed = 0;

  deadlock_block_timeout_reporter #(
    .NUM_AXIS(2), .NUM_INST(1), .TIMEOUT(8), .CNT_W(4)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .kernel_block     (kernel_block),
    .axis_block_sigs  (axis_block_sigs),
    .inst_block_sigs  (inst_block_sigs),
    .clear            (clear),
    .deadlock         (deadlock),
    .deadlock_pulse   (deadlock_pulse),
    .blocked_snapshot (blocked_snapshot),
    .first_blocked_idx(first_blocked_idx),
    .snapshot_valid   (snapshot_valid),
    .block_cycles     (block_cycles),
    .transient_count  (transient_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    assert (act === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic check_out(input exp_t e);
    chk(e.tag, "deadlock",  32'(deadlock),          32'(e.dl));
    chk(e.tag, "pulse",     32'(deadlock_pulse),    32'(e.pl));
    chk(e.tag, "snapshot",  32'(blocked_snapshot),  32'(e.snap));
    chk(e.tag, "first_idx", 32'(first_blocked_idx), 32'(e.idx));
    chk(e.tag, "snap_vld",  32'(snapshot_valid),    32'(e.val));
    chk(e.tag, "block_cyc", 32'(block_cycles),      32'(e.bc));
    chk(e.tag, "transient", 32'(transient_count),   32'(e.tc));
  endtask

  function automatic exp_t mk(input string tag, input logic dl, input logic pl,
                              input logic [2:0] snap, input logic [1:0] idx,
                              input logic val, input logic [3:0] bc, input logic [3:0] tc);
    exp_t e;
    e.tag = tag; e.dl = dl; e.pl = pl; e.snap = snap; e.idx = idx;
    e.val = val; e.bc = bc; e.tc = tc;
    return e;
  endfunction

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
  task automatic step(input logic kb, input logic [1:0] ax, input logic in, input logic clr,
                      input string tag, input logic dl, input logic pl, input logic [2:0] snap,
                      input logic [1:0] idx, input logic val, input logic [3:0] bc,
                      input logic [3:0] tc);
    exp_t e;
    kernel_block    = kb;
    axis_block_sigs = ax;
    inst_block_sigs = in;
    clear           = clr;
    sb.push_back(mk(tag, dl, pl, snap, idx, val, bc, tc));
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check_out(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #7 check_out(mk("reset", 0, 0, 3'b000, 2'd0, 0, 4'd0, 4'd0));
    #4 reset_n = 1'b1;

    // Transient run of 5 cycles
    for (int k = 1; k <= 5; k++) step(1, 2'b00, 0, 0, "trans_run", 0, 0, 0, 0, 0, 4'(k), 4'd0);
    step(0, 2'b00, 0, 0, "trans_end",  0, 0, 0, 0, 0, 4'd0, 4'd1);
    step(0, 2'b00, 0, 0, "trans_idle", 0, 0, 0, 0, 0, 4'd0, 4'd1);

    // Declaration on the 8th blocked cycle
    for (int k = 1; k <= 7; k++) step(1, 2'b10, 0, 0, "decl_ramp", 0, 0, 0, 0, 0, 4'(k), 4'd1);
    step(1, 2'b10, 0, 0, "decl_edge", 1, 1, 3'b010, 2'd1, 1, 4'd8, 4'd1);
    step(1, 2'b10, 0, 0, "decl_post", 1, 0, 3'b010, 2'd1, 1, 4'd9, 4'd1);

    // Sticky report while the block drops and ports change
    step(0, 2'b01, 0, 0, "sticky_a", 1, 0, 3'b010, 2'd1, 1, 4'd9, 4'd1);
    step(0, 2'b01, 0, 0, "sticky_b", 1, 0, 3'b010, 2'd1, 1, 4'd9, 4'd1);
    step(1, 2'b01, 0, 0, "sticky_c", 1, 0, 3'b010, 2'd1, 1, 4'd10, 4'd1);

    // Clear out of DEADLOCK
    step(0, 2'b00, 0, 1, "clr_dl",   0, 0, 0, 0, 0, 4'd0, 4'd1);
    step(0, 2'b00, 0, 0, "clr_idle", 0, 0, 0, 0, 0, 4'd0, 4'd1);

    // Clear coincident with the declaring edge wins
    for (int k = 1; k <= 7; k++) step(1, 2'b11, 0, 0, "clr8_ramp", 0, 0, 0, 0, 0, 4'(k), 4'd1);
    step(1, 2'b11, 0, 1, "clr8_edge",    0, 0, 0, 0, 0, 4'd0, 4'd1);
    step(1, 2'b11, 0, 0, "clr8_restart", 0, 0, 0, 0, 0, 4'd1, 4'd1);
    step(1, 2'b11, 0, 0, "clr8_cnt2",    0, 0, 0, 0, 0, 4'd2, 4'd1);
    step(0, 2'b00, 0, 0, "clr8_end",     0, 0, 0, 0, 0, 4'd0, 4'd2);

    // Asynchronous reset mid-run
    for (int k = 1; k <= 5; k++) step(1, 2'b00, 0, 0, "rst_ramp", 0, 0, 0, 0, 0, 4'(k), 4'd2);
    #3 reset_n = 1'b0;
    #1 check_out(mk("rst_async", 0, 0, 3'b000, 2'd0, 0, 4'd0, 4'd0));
    kernel_block = 1'b0;
    #2 reset_n = 1'b1;

    // Fresh 8-cycle block after reset, instance line set, then saturation
    for (int k = 1; k <= 7; k++) step(1, 2'b00, 1, 0, "post_ramp", 0, 0, 0, 0, 0, 4'(k), 4'd0);
    step(1, 2'b00, 1, 0, "post_edge", 1, 1, 3'b100, 2'd2, 1, 4'd8, 4'd0);
    for (int k = 9; k <= 17; k++)
      step(1, 2'b00, 1, 0, "sat_bc", 1, 0, 3'b100, 2'd2, 1, (k > 15) ? 4'd15 : 4'(k), 4'd0);
    step(0, 2'b00, 0, 1, "sat_clr", 0, 0, 0, 0, 0, 4'd0, 4'd0);

    // Empty snapshot: kernel block with no port bits
    for (int k = 1; k <= 7; k++) step(1, 2'b00, 0, 0, "empty_ramp", 0, 0, 0, 0, 0, 4'(k), 4'd0);
    step(1, 2'b00, 0, 0, "empty_edge", 1, 1, 3'b000, 2'd0, 0, 4'd8, 4'd0);
    step(0, 2'b00, 0, 1, "empty_clr",  0, 0, 0, 0, 0, 4'd0, 4'd0);

    // Transient counter saturation
    for (int n = 1; n <= 17; n++) begin
      step(1, 2'b00, 0, 0, "tc_hi", 0, 0, 0, 0, 0, 4'd1, (n - 1 > 15) ? 4'd15 : 4'(n - 1));
      step(0, 2'b00, 0, 0, "tc_lo", 0, 0, 0, 0, 0, 4'd0, (n > 15) ? 4'd15 : 4'(n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
